// File: rtl/adder_seq_chunked.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock through a registered carry,
// with ADD/SUB/ADC/SBB modes, start/busy/done handshake and x86-style flags.
module adder_seq_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             OF,
  output logic             CF,
  output logic             ZF,
  output logic             SF,
  output logic             PF
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             c;
  logic             sub_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;

  logic             sub_in;
  logic             c_init;
  logic             last;
  logic             cmsb;
  int               base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] bx_ch;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] s_next;

  // mode[0] selects subtraction; mode[1] selects the carry-in variants
  assign sub_in = mode[0];
  assign c_init = mode[1] ? (cin ^ mode[0]) : mode[0];
  assign last   = (idx == LAST);

  always_comb begin
    base   = int'(idx) * CHUNK;
    a_ch   = a_q[base +: CHUNK];
    bx_ch  = bx_q[base +: CHUNK];
    csum   = {1'b0, a_ch} + {1'b0, bx_ch} + {{CHUNK{1'b0}}, c};
    // carry into the chunk MSB recovered from its sum bit; equals c when CHUNK=1
    cmsb   = a_ch[CHUNK-1] ^ bx_ch[CHUNK-1] ^ csum[CHUNK-1];
    s_next = s;
    s_next[base +: CHUNK] = csum[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      OF    <= 1'b0;
      CF    <= 1'b0;
      ZF    <= 1'b0;
      SF    <= 1'b0;
      PF    <= 1'b0;
      idx   <= '0;
      c     <= 1'b0;
      sub_q <= 1'b0;
      a_q   <= '0;
      bx_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            bx_q  <= B ^ {WIDTH{sub_in}};
            sub_q <= sub_in;
            c     <= c_init;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s <= s_next;
          c <= csum[CHUNK];
          if (last) begin
            idx   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            CF    <= csum[CHUNK] ^ sub_q;
            OF    <= csum[CHUNK] ^ cmsb;
            SF    <= s_next[WIDTH-1];
            ZF    <= (s_next == '0);
            PF    <= ^s_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed bench for adder_seq_chunked at default parameters (WIDTH=32, CHUNK=8).
module tb_adder_seq_chunked;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        cin;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        OF, CF, ZF, SF, PF;

  int total = 0;
  int bad   = 0;
  logic [4:0] pflags = 5'b0;   // {OF,CF,ZF,SF,PF} expected to be held

  adder_seq_chunked #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cin(cin),
    .A(A), .B(B), .busy(busy), .done(done), .s(s),
    .OF(OF), .CF(CF), .ZF(ZF), .SF(SF), .PF(PF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic ci,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic [4:0] ef);
    int n;
    @(negedge clk);
    mode = m; cin = ci; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; mode = ~m; cin = ~ci;
    n = 1;
    chk({tag, ":busy"}, 64'(busy), 64'd1);
    chk({tag, ":flags_hold"}, 64'({OF, CF, ZF, SF, PF}), 64'(pflags));
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ":latency"}, 64'(n), 64'd5);
    chk({tag, ":s"}, 64'(s), 64'(es));
    chk({tag, ":flags"}, 64'({OF, CF, ZF, SF, PF}), 64'(ef));
    chk({tag, ":busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, ":done_pulse"}, 64'(done), 64'd0);
    pflags = ef;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; cin = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:s", 64'(s), 64'd0);
    chk("reset:flags", 64'({OF, CF, ZF, SF, PF}), 64'd0);
    rst = 1'b0;

    // flags order {OF,CF,ZF,SF,PF}
    run_op("add_wrap",  2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b01100);
    run_op("sub_of",    2'b01, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b10001);
    run_op("sub_neg",   2'b01, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 5'b01011);
    run_op("adc_of",    2'b10, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5'b10011);
    run_op("sbb_5_3",   2'b11, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 5'b00001);
    run_op("add_chunk", 2'b00, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 5'b00001);
    run_op("adc_wrap",  2'b10, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 5'b01100);
    run_op("sbb_borrow",2'b11, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 5'b01010);
    run_op("adc_cin0",  2'b10, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'b00000);
    run_op("sub_zero",  2'b01, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 5'b00100);
    run_op("add_of",    2'b00, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b10011);

    // start held for 10 cycles while A changes every cycle
    @(negedge clk);
    mode = 2'b00; cin = 1'b0; B = 32'h1; A = 32'h1111_1111; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("hs:done1", 64'(done), 64'd1);
        chk("hs:s1", 64'(s), 64'h1111_1112);
        chk("hs:busy1", 64'(busy), 64'd0);
      end else if (k == 10) begin
        chk("hs:done2", 64'(done), 64'd1);
        chk("hs:s2", 64'(s), 64'h6666_6667);
      end else begin
        chk($sformatf("hs:done_k%0d", k), 64'(done), 64'd0);
        chk($sformatf("hs:busy_k%0d", k), 64'(busy), 64'd1);
      end
      if (k < 10) A = 32'h1111_1111 * (k + 1);
      else start = 1'b0;
    end

    // reset after E2 of an operation
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h1111_1111; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst:partial_s", 64'(s), 64'h6666_6789);
    chk("rst:busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:s", 64'(s), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:flags", 64'({OF, CF, ZF, SF, PF}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("rst:no_done", 64'(seen), 64'd0);
    end
    pflags = 5'b0;
    run_op("after_rst", 2'b00, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
